// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that time-shares one iterative Booth multiplier.
// Launches operands, waits on mul_done with a watchdog, returns the product.
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [2*WIDTH-1:0]    resp_result,
  output logic                  resp_err,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_result
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [WDW-1:0] wdog;
  logic           any_req;
  logic [IDW-1:0] win;
  logic [IDW:0]   scan;

  // Scan starts at rr_ptr and wraps modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    scan    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!any_req && req_valid[scan[IDW-1:0]]) begin
        any_req = 1'b1;
        win     = scan[IDW-1:0];
      end
    end
  end

  assign req_ready  = (state == IDLE && any_req) ? (ONE << win) : '0;
  assign resp_valid = (state == RESP) ? (ONE << grant_id) : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wdog        <= '0;
      grant_id    <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            mul_a     <= req_a[int'(win)*WIDTH +: WIDTH];
            mul_b     <= req_b[int'(win)*WIDTH +: WIDTH];
            grant_id  <= win;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion in the final watchdog cycle still counts.
          if (mul_done) begin
            resp_result <= mul_result;
            resp_err    <= 1'b0;
            state       <= RESP;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            state       <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[grant_id]) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0
                    : grant_id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a 9-cycle signed-multiply engine.
// Hand-computed vectors cover arbitration, backpressure, timeout and reset.
module tb_booth_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [15:0] resp_result;
  logic        resp_err;
  logic [1:0]  grant_id;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int eng_cnt = 0;
  logic eng_en = 1'b1;
  logic signed [15:0] prod;
  int g;

  booth_mult_arbiter #(
    .NREQ(4), .WIDTH(8), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .grant_id(grant_id), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Engine model: not reset, so an abandoned launch still pulses later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_start) eng_cnt <= 9;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end

  assign prod       = 16'($signed(mul_a)) * 16'($signed(mul_b));
  assign mul_done   = eng_en && (eng_cnt == 1);
  assign mul_result = mul_done ? prod : 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a,
                        input logic [7:0] b);
    req_a[k*8 +: 8] = a;
    req_b[k*8 +: 8] = b;
  endtask

  task automatic wait_resp(input string tag, input int gc, input int lat);
    int n = 0;
    while (resp_valid == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(cyc - gc), 32'(lat));
  endtask

  task automatic finish_resp(input int k);
    resp_ready = 4'h0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready = 4'h0;
    #1 chk("resp_clr", 32'(resp_valid), 32'h0);
  endtask

  logic [1:0]  ord [5];
  logic [15:0] exp4 [4];

  initial begin
    rst_n = 1'b0;
    req_valid = 4'h0;
    req_a = 32'h0;
    req_b = 32'h0;
    resp_ready = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_result", 32'(resp_result), 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(mul_start), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);

    // Requests 0 and 2 together out of reset.
    set_op(0, 8'd7, 8'd6);
    set_op(2, 8'hFD, 8'd4);
    req_valid = 4'b0101;
    rst_n = 1'b1;
    #1 chk("sim_rdy0", 32'(req_ready), 32'h1);
    g = cyc;
    @(negedge clk);
    req_valid = 4'b0100;
    chk("sim_start", 32'(mul_start), 32'h1);
    chk("sim_gid0", 32'(grant_id), 32'h0);
    chk("sim_busy", 32'(busy), 32'h1);
    wait_resp("sim0", g, 11);
    chk("sim0_valid", 32'(resp_valid), 32'h1);
    chk("sim0_res", 32'(resp_result), 32'h002A);
    chk("sim0_err", 32'(resp_err), 32'h0);
    finish_resp(0);
    chk("sim_rdy2", 32'(req_ready), 32'h4);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    wait_resp("sim2", g, 11);
    chk("sim2_valid", 32'(resp_valid), 32'h4);
    chk("sim2_res", 32'(resp_result), 32'hFFF4);
    finish_resp(2);

    // rr_ptr is now 3, so 3 beats 0.
    set_op(3, 8'd2, 8'd2);
    set_op(0, 8'd9, 8'd9);
    req_valid = 4'b1001;
    #1 chk("rr3_rdy", 32'(req_ready), 32'h8);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    wait_resp("rr3", g, 11);
    chk("rr3_res", 32'(resp_result), 32'h0004);
    finish_resp(3);

    // All four requesting continuously.
    set_op(0, 8'h80, 8'h80);
    set_op(1, 8'h7F, 8'h80);
    set_op(2, 8'hFF, 8'h7F);
    set_op(3, 8'h00, 8'd55);
    exp4[0] = 16'h4000;
    exp4[1] = 16'hC080;
    exp4[2] = 16'hFF81;
    exp4[3] = 16'h0000;
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2;
    ord[3] = 2'd3; ord[4] = 2'd0;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1 chk("all_rdy", 32'(req_ready), 32'(4'b0001 << ord[i]));
      g = cyc;
      @(negedge clk);
      if (i == 4) req_valid = 4'h0;
      chk("all_gid", 32'(grant_id), 32'(ord[i]));
      wait_resp("all", g, 11);
      chk("all_valid", 32'(resp_valid), 32'(4'b0001 << ord[i]));
      chk("all_res", 32'(resp_result), 32'(exp4[ord[i]]));
      finish_resp(int'(ord[i]));
    end

    // Single request from 1: 3 * -5.
    set_op(1, 8'd3, 8'hFB);
    req_valid = 4'b0010;
    #1 chk("one_rdy", 32'(req_ready), 32'h2);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    chk("one_start", 32'(mul_start), 32'h1);
    chk("one_gid", 32'(grant_id), 32'h1);
    chk("one_mul_a", 32'(mul_a), 32'h03);
    chk("one_mul_b", 32'(mul_b), 32'hFB);
    @(negedge clk);
    chk("one_start_pulse", 32'(mul_start), 32'h0);
    wait_resp("one", g, 11);
    chk("one_valid", 32'(resp_valid), 32'h2);
    chk("one_res", 32'(resp_result), 32'hFFF1);
    chk("one_err", 32'(resp_err), 32'h0);
    resp_ready = 4'b1101;
    @(negedge clk);
    chk("one_other_ready", 32'(resp_valid), 32'h2);
    finish_resp(1);

    // Backpressure on requester 2 with 0 waiting.
    set_op(2, 8'hFF, 8'hFF);
    set_op(0, 8'd10, 8'hF6);
    req_valid = 4'b0100;
    #1 chk("bp_rdy", 32'(req_ready), 32'h4);
    g = cyc;
    @(negedge clk);
    req_valid = 4'b0001;
    wait_resp("bp", g, 11);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'h4);
      chk("bp_res", 32'(resp_result), 32'h0001);
      chk("bp_rdy_low", 32'(req_ready), 32'h0);
    end
    finish_resp(2);

    // Timeout: engine silent for requester 0.
    eng_en = 1'b0;
    chk("to_rdy", 32'(req_ready), 32'h1);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    wait_resp("to", g, 17);
    chk("to_valid", 32'(resp_valid), 32'h1);
    chk("to_err", 32'(resp_err), 32'h1);
    chk("to_res", 32'(resp_result), 32'h0);
    finish_resp(0);
    eng_en = 1'b1;

    // Normal service after the timeout.
    set_op(1, 8'd5, 8'hF9);
    req_valid = 4'b1010;
    #1 chk("post_rdy", 32'(req_ready), 32'h2);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    wait_resp("post", g, 11);
    chk("post_res", 32'(resp_result), 32'hFFDD);
    chk("post_err", 32'(resp_err), 32'h0);
    finish_resp(1);

    // Reset while waiting on the engine.
    set_op(2, 8'd6, 8'd6);
    req_valid = 4'b0100;
    #1 chk("mr_rdy", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'h0;
    repeat (3) @(negedge clk);
    chk("mr_busy_wait", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_valid", 32'(resp_valid), 32'h0);
    chk("mr_res", 32'(resp_result), 32'h0);
    chk("mr_err", 32'(resp_err), 32'h0);
    chk("mr_gid", 32'(grant_id), 32'h0);
    chk("mr_mul_a", 32'(mul_a), 32'h0);
    chk("mr_mul_b", 32'(mul_b), 32'h0);
    chk("mr_start", 32'(mul_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("mr_stale_valid", 32'(resp_valid), 32'h0);
      chk("mr_stale_busy", 32'(busy), 32'h0);
    end
    set_op(0, 8'hFE, 8'd3);
    req_valid = 4'b0101;
    #1 chk("mr_rdy0", 32'(req_ready), 32'h1);
    g = cyc;
    @(negedge clk);
    req_valid = 4'h0;
    wait_resp("mr0", g, 11);
    chk("mr0_valid", 32'(resp_valid), 32'h1);
    chk("mr0_res", 32'(resp_result), 32'hFFFA);
    finish_resp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
